// File: rtl/fir_out_requant.sv
// Requantizes signed FIR results (round half up, shift 0..3) into an OUT_W-bit output FIFO.
// Optional clamping with sticky sat_flag when FIR_OUT_SAT_EN is defined; otherwise wrap-around.
module fir_out_requant #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [1:0]               shift_sel,
    output logic [OUT_W-1:0]         m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CW-1:0]          count, count_next;
    logic                   push, pop;

    logic signed [IN_W:0]   ext, rnd, sum, shifted;
    logic [OUT_W-1:0]       req_val;
    logic                   clip;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        ext = {s_axis_tdata[IN_W-1], s_axis_tdata};
        rnd = '0;
        case (shift_sel)
            2'd1:    rnd[0] = 1'b1;
            2'd2:    rnd[1] = 1'b1;
            2'd3:    rnd[2] = 1'b1;
            default: rnd = '0;
        endcase
        sum     = ext + rnd;
        shifted = sum >>> shift_sel;
    end

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        clip    = 1'b0;
        req_val = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            clip    = 1'b1;
            req_val = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            clip    = 1'b1;
            req_val = MIN_V[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            sat_flag <= 1'b0;
        else if (push && clip)
            sat_flag <= 1'b1;
        else if (sat_clr)
            sat_flag <= 1'b0;
    end
`else
    logic unused_sat;

    assign clip       = 1'b0;
    assign req_val    = shifted[OUT_W-1:0];
    assign sat_flag   = 1'b0;
    assign unused_sat = ^{sat_clr, clip, shifted[IN_W:OUT_W]};
`endif

    assign s_axis_tready = (count < DEPTH_C);
    assign m_axis_tvalid = (count != '0);
    assign fifo_count    = count;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign rd_ptr_inc    = rd_ptr + AW'(1);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= req_val;
    end

    // m_axis_tdata is a registered copy of the head; it only moves when the head changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            m_axis_tdata <= '0;
        end else begin
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr_inc;
            if ((pop || push) && (count_next != '0)) begin
                if ((count == '0) || (pop && (count == CW'(1))))
                    m_axis_tdata <= req_val;
                else if (pop)
                    m_axis_tdata <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 Parameter IN_W, default 11, width of the signed FIR result accepted from the filter.
REQ-002 Parameter OUT_W, default 8, width of the requantized signed output sample.
REQ-003 Parameter DEPTH, default 4, number of output FIFO entries; legal values are powers of two from 2 to 16.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous reset, active-high.
REQ-006 Port s_axis_tdata  input  IN_W  signed two's-complement FIR output sample.
REQ-007 Port s_axis_tvalid  input  1  upstream sample valid.
REQ-008 Port s_axis_tready  output  1  block can accept a sample.
REQ-009 Port shift_sel  input  2  right-shift amount, 0 to 3, applied per sample.
REQ-010 Port m_axis_tdata  output  OUT_W  requantized sample at the FIFO head.
REQ-011 Port m_axis_tvalid  output  1  FIFO non-empty.
REQ-012 Port m_axis_tready  input  1  downstream accepts the head sample.
REQ-013 Port fifo_count  output  clog2(DEPTH)+1  current occupancy.
REQ-014 Port sat_flag  output  1  sticky flag, set when any accepted sample was clipped.
REQ-015 Port sat_clr  input  1  clears sat_flag.

Function
REQ-016 A push shall occur when s_axis_tvalid and s_axis_tready are both high on a clock edge; shift_sel shall be sampled on that edge.
REQ-017 A pop shall occur when m_axis_tvalid and m_axis_tready are both high on a clock edge.
REQ-018 Requantization shall be combinational on push: sign-extend to IN_W+1 bits, add 2^(shift_sel-1) when shift_sel>0 (round half up), arithmetic right shift by shift_sel, then reduce to OUT_W bits per REQ-031/REQ-032.
REQ-019 A pushed sample shall appear on m_axis_tdata with m_axis_tvalid high on the cycle after the push edge when the FIFO was empty; latency is 1 cycle.
REQ-020 s_axis_tready shall equal (fifo_count < DEPTH), registered-state only, with no combinational path from m_axis_tready.
REQ-021 When full, no push shall occur even if a pop occurs on the same edge.
REQ-022 A simultaneous push and pop on a non-full, non-empty FIFO shall leave fifo_count unchanged and preserve FIFO order.
REQ-023 When empty, m_axis_tvalid shall be low and m_axis_tdata shall hold its last value; m_axis_tready shall have no effect.
REQ-024 Read and write pointers shall wrap modulo DEPTH.
REQ-025 m_axis_tdata shall remain stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-026 sat_flag shall set on the edge of a push whose sample clipped; sat_clr shall clear it; if both occur on one edge, set shall win.

Reset
REQ-027 While reset is high on a clock edge, pointers and fifo_count shall go to 0, m_axis_tvalid to 0, m_axis_tdata to 0, and sat_flag to 0.
REQ-028 s_axis_tready shall be 1 on the first cycle after reset deasserts.
REQ-029 A reset asserted mid-stream shall discard all buffered samples with no pop handshake; a push or pop presented on the reset edge shall be ignored.
REQ-030 FIFO storage contents need not be reset.

Configuration
REQ-031 With macro FIR_OUT_SAT_EN defined, out-of-range results shall clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1), and clipping shall set sat_flag.
REQ-032 Without FIR_OUT_SAT_EN, results shall be truncated to the low OUT_W bits (wrap-around), and sat_flag shall be tied to 0.

Verification
REQ-033 Reset, then push 0x07F with shift_sel=0 and m_axis_tready=1 -> next cycle m_axis_tdata=0x7F, tvalid=1, fifo_count=1.
REQ-034 Push 0x00B with shift_sel=2 -> output 0x03 (11+2=13, >>2=3); push 0x7F5 (-11) with shift_sel=2 -> output 0xFD (-3).
REQ-035 Push 0x3FF with shift_sel=0 -> with FIR_OUT_SAT_EN, output 0x7F and sat_flag=1; without it, output 0xFF and sat_flag=0; then pulse sat_clr -> sat_flag=0.
REQ-036 Hold m_axis_tready=0 and push 5 samples with DEPTH=4 -> s_axis_tready goes low after the 4th push, the 5th is not accepted, and the head data stays stable; release tready -> 4 samples emerge in order.
REQ-037 Stream continuous tvalid with toggling tready for 20 samples through the pointer wrap -> output sequence equals input sequence with no loss or duplication.
REQ-038 Assert reset with 3 entries buffered -> next cycle tvalid=0, fifo_count=0, s_axis_tready=1.
